branch_predict_unit: RTL

Parametrised successor to the combinational jump/branch resolver. It resolves J/JAL/JR/JALR/BEQZ/BNEZ in EX and adds a direct-mapped branch target buffer (BTB) with saturating direction counters, so IF gets a taken/target prediction. Prediction is checked at resolve time. A mispredict produces a registered redirect and flush. JAL/JALR produce an R31 link write.

---
 rtl/bpu_pkg.sv | 44 ++++
 rtl/branch_target_buffer.sv | 89 ++++++++
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: DLX control opcodes,
// control-instruction classification and saturating counter helpers.
package bpu_pkg;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  typedef enum logic [2:0] {
    CK_NONE,
    CK_COND,
    CK_JUMP,
    CK_JUMP_LINK,
    CK_JUMP_REG,
    CK_JUMP_REG_LINK
  } ctrl_kind_t;

  function automatic ctrl_kind_t decode_kind(input logic [5:0] op);
    case (op)
      OP_BEQZ, OP_BNEZ: return CK_COND;
      OP_J:             return CK_JUMP;
      OP_JAL:           return CK_JUMP_LINK;
      OP_JR:            return CK_JUMP_REG;
      OP_JALR:          return CK_JUMP_REG_LINK;
      default:          return CK_NONE;
    endcase
  endfunction

  // Counters are passed as 32-bit values so one helper serves any width.
  function automatic int unsigned ctr_sat_inc(input int unsigned ctr, input int unsigned bits);
    int unsigned max_v;
    max_v = (32'd1 << bits) - 32'd1;
    return (ctr >= max_v) ? max_v : ctr + 32'd1;
  endfunction

  function automatic int unsigned ctr_sat_dec(input int unsigned ctr, input int unsigned bits);
    if (bits == 0) return 32'd0;
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, one resolve-side update port that
// does its own read-modify-write of the direction counter, one invalidate port.
module branch_target_buffer
  import bpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic            wr_uncond,
  input  logic [XLEN-1:0] wr_target,
  input  logic            inv_en,
  input  logic [XLEN-1:0] inv_pc
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(32'd1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX-1:0]  rd_idx, wr_idx, inv_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            wr_hit;
  logic [CTR_BITS-1:0] ctr_next;

  assign rd_idx  = rd_pc[IDX+1:2];
  assign rd_tag  = rd_pc[XLEN-1:IDX+2];
  assign wr_idx  = wr_pc[IDX+1:2];
  assign wr_tag  = wr_pc[XLEN-1:IDX+2];
  assign inv_idx = inv_pc[IDX+1:2];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Next counter value for the resolving entry: jumps pin to max, fresh
  // conditional allocations start weakly taken.
  always_comb begin
    ctr_next = ctr_q[wr_idx];
    if (wr_uncond)
      ctr_next = CTR_MAX;
    else if (!wr_hit)
      ctr_next = CTR_WEAK_T;
    else if (wr_taken)
      ctr_next = CTR_BITS'(ctr_sat_inc(32'(ctr_q[wr_idx]), CTR_BITS));
    else
      ctr_next = CTR_BITS'(ctr_sat_dec(32'(ctr_q[wr_idx]), CTR_BITS));
  end

  // Valid bits and counters: reset to empty/weakly not-taken, then update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WEAK_NT;
    end else if (inv_en) begin
      valid_q[inv_idx] <= 1'b0;
    end else if (wr_en && (wr_hit || wr_taken)) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= ctr_next;
    end
  end

  // Tag and target carry no reset; they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken && !inv_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve for J/JAL/JR/JALR/BEQZ/BNEZ with BTB-based prediction,
// registered redirect/flush on mispredict and registered R31 link write.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [31:0]     ex_instruction,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            link_we,
  output logic [XLEN-1:0] link_data,
  output logic [15:0]     mispredict_count
);

  ctrl_kind_t      kind;
  logic            is_ctrl, is_uncond, is_link;
  logic            taken, mispredict, accept;
  logic [XLEN-1:0] ex_pc4, target, next_pc;
  logic [XLEN-1:0] off_j, off_b;

  logic            btb_hit;
  logic [XLEN-1:0] btb_target;
  logic [CTR_BITS-1:0] btb_ctr;

  logic            redirect_q, shadow_q, link_we_q;
  logic [XLEN-1:0] redirect_pc_q, link_data_q;
  logic [15:0]     mis_cnt_q;

  branch_target_buffer #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (if_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .rd_ctr    (btb_ctr),
    .wr_en     (accept && is_ctrl),
    .wr_pc     (ex_pc),
    .wr_taken  (taken),
    .wr_uncond (is_uncond),
    .wr_target (target),
    .inv_en    (accept && !is_ctrl && ex_pred_taken),
    .inv_pc    (ex_pc)
  );

  assign pred_taken  = btb_hit && btb_ctr[CTR_BITS-1];
  assign pred_target = btb_hit ? btb_target : (if_pc + XLEN'(32'd4));

  assign ex_pc4 = ex_pc + XLEN'(32'd4);
  assign off_j  = {{(XLEN-26){ex_instruction[25]}}, ex_instruction[25:0]};
  assign off_b  = {{(XLEN-16){ex_instruction[15]}}, ex_instruction[15:0]};

  // Decode, actual direction and target of the instruction in EX.
  always_comb begin
    kind   = decode_kind(ex_instruction[31:26]);
    target = ex_pc4;
    taken  = 1'b0;
    case (kind)
      CK_COND: begin
        target = ex_pc4 + off_b;
        taken  = (ex_instruction[31:26] == OP_BNEZ) ? (ex_rs1 != '0) : (ex_rs1 == '0);
      end
      CK_JUMP, CK_JUMP_LINK: begin
        target = ex_pc4 + off_j;
        taken  = 1'b1;
      end
      CK_JUMP_REG, CK_JUMP_REG_LINK: begin
        target = ex_rs1;
        taken  = 1'b1;
      end
      default: begin
        target = ex_pc4;
        taken  = 1'b0;
      end
    endcase
  end

  assign is_ctrl    = (kind != CK_NONE);
  assign is_uncond  = is_ctrl && (kind != CK_COND);
  assign is_link    = (kind == CK_JUMP_LINK) || (kind == CK_JUMP_REG_LINK);
  assign next_pc    = taken ? target : ex_pc4;
  // A non-control instruction predicted taken falls out here as taken != pred.
  assign mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
  // The instruction right behind a redirect is wrong-path and is dropped.
  assign accept     = ex_valid && !shadow_q;

  // Redirect, link, shadow and mispredict statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      shadow_q      <= 1'b0;
      link_we_q     <= 1'b0;
      link_data_q   <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q <= accept && mispredict;
      shadow_q   <= accept && mispredict;
      link_we_q  <= accept && is_link;
      if (accept && mispredict) begin
        redirect_pc_q <= next_pc;
        if (mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
      end
      if (accept && is_link) link_data_q <= ex_pc4;
    end
  end

  assign redirect_valid   = redirect_q;
  assign flush            = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign link_we          = link_we_q;
  assign link_data        = link_data_q;
  assign mispredict_count = mis_cnt_q;

endmodule
